// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, Status/Cause field positions and ExcCodes.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int IP_TIMER  = 7;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Datapath <-> CP0 bundle: retire info, mfc0/mtc0 access, fetch redirect and debug taps.
interface cp0_exc_ctrl_if #(
  parameter int DW   = 32,
  parameter int NIRQ = 6
);
  logic            inst_valid;
  logic [DW-1:0]   inst_pc;
  logic [DW-1:0]   next_pc;
  logic            exc_req;
  logic [4:0]      exc_code;
  logic [NIRQ-1:0] irq;
  logic            eret;
  logic [4:0]      cp0_raddr;
  logic [DW-1:0]   cp0_rdata;
  logic            cp0_we;
  logic [4:0]      cp0_waddr;
  logic [DW-1:0]   cp0_wdata;
  logic            redirect;
  logic [DW-1:0]   redirect_pc;
  logic [DW-1:0]   status_o;
  logic [DW-1:0]   cause_o;
  logic [DW-1:0]   epc_o;

  modport master (
    output inst_valid, inst_pc, next_pc, exc_req, exc_code, irq, eret,
           cp0_raddr, cp0_we, cp0_waddr, cp0_wdata,
    input  cp0_rdata, redirect, redirect_pc, status_o, cause_o, epc_o
  );

  modport slave (
    input  inst_valid, inst_pc, next_pc, exc_req, exc_code, irq, eret,
           cp0_raddr, cp0_we, cp0_waddr, cp0_wdata,
    output cp0_rdata, redirect, redirect_pc, status_o, cause_o, epc_o
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare pair with free-running increment and a sticky match flag.
module cp0_timer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          count_we,
  input  logic          compare_we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] count,
  output logic [DW-1:0] compare,
  output logic          pending
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '1;
      pending <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + DW'(1);
      if (compare_we) compare <= wdata;
      // A Compare write acknowledges the timer, even against a same-cycle match.
      if (compare_we)              pending <= 1'b0;
      else if (count == compare)   pending <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0: Status/Cause/EPC, exception/interrupt/eret arbitration and fetch redirect.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            NIRQ     = 6,
  parameter logic [DW-1:0] VEC_ADDR = 32'h0000_0008,
  parameter bit            TIMER_EN = 1'b1
) (
  input logic           Clk,
  input logic           Rst,
  cp0_exc_ctrl_if.slave bus
);

  logic            ie, exl;
  logic [7:0]      im, ip;
  logic [4:0]      exc_code_q;
  logic [NIRQ-1:0] irq_q;
  logic [DW-1:0]   epc, count, compare, status_w, cause_w;
  logic            timer_pend;
  logic            exc_take, int_take, eret_take, hw_take;
  logic            wr_status, wr_cause, wr_epc;

  always_comb begin
    ip = '0;
    ip[NIRQ-1:0] = irq_q;
    ip[IP_TIMER] = timer_pend;
  end

  assign exc_take  = bus.inst_valid & bus.exc_req;
  assign int_take  = bus.inst_valid & ie & ~exl & (|(ip & im)) & ~bus.eret & ~bus.exc_req;
  assign eret_take = bus.inst_valid & bus.eret & ~bus.exc_req;
  assign hw_take   = exc_take | int_take;

  // Software writes to Status/Cause/EPC yield to any take in the same cycle.
  assign wr_status = bus.cp0_we & (bus.cp0_waddr == CP0_STATUS) & ~hw_take & ~eret_take;
  assign wr_cause  = bus.cp0_we & (bus.cp0_waddr == CP0_CAUSE)  & ~hw_take & ~eret_take;
  assign wr_epc    = bus.cp0_we & (bus.cp0_waddr == CP0_EPC)    & ~hw_take & ~eret_take;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ie         <= 1'b0;
      exl        <= 1'b0;
      im         <= '0;
      exc_code_q <= '0;
      irq_q      <= '0;
      epc        <= '0;
    end else begin
      irq_q <= bus.irq;
      if (hw_take) begin
        exl        <= 1'b1;
        exc_code_q <= exc_take ? bus.exc_code : 5'(EXC_INT);
        if (int_take)  epc <= bus.next_pc;
        else if (!exl) epc <= bus.inst_pc;
      end else if (eret_take) begin
        exl <= 1'b0;
      end
      if (wr_status) begin
        ie  <= bus.cp0_wdata[ST_IE];
        exl <= bus.cp0_wdata[ST_EXL];
        im  <= bus.cp0_wdata[ST_IM_LO +: 8];
      end
      if (wr_cause) exc_code_q <= bus.cp0_wdata[CA_EXC_LO +: 5];
      if (wr_epc)   epc        <= bus.cp0_wdata;
    end
  end

  if (TIMER_EN) begin : g_timer
    cp0_timer #(.DW(DW)) u_timer (
      .clk        (Clk),
      .rst        (Rst),
      .count_we   (bus.cp0_we && (bus.cp0_waddr == CP0_COUNT)),
      .compare_we (bus.cp0_we && (bus.cp0_waddr == CP0_COMPARE)),
      .wdata      (bus.cp0_wdata),
      .count      (count),
      .compare    (compare),
      .pending    (timer_pend)
    );
  end else begin : g_no_timer
    assign count      = '0;
    assign compare    = '0;
    assign timer_pend = 1'b0;
  end

  always_comb begin
    status_w = '0;
    status_w[ST_IE]           = ie;
    status_w[ST_EXL]          = exl;
    status_w[ST_IM_LO +: 8]   = im;
    cause_w = '0;
    cause_w[CA_EXC_LO +: 5]   = exc_code_q;
    cause_w[CA_IP_LO +: 8]    = ip;
  end

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_raddr)
      CP0_COUNT:   bus.cp0_rdata = count;
      CP0_COMPARE: bus.cp0_rdata = compare;
      CP0_STATUS:  bus.cp0_rdata = status_w;
      CP0_CAUSE:   bus.cp0_rdata = cause_w;
      CP0_EPC:     bus.cp0_rdata = epc;
      default:     bus.cp0_rdata = '0;
    endcase
  end

  assign bus.redirect    = hw_take | eret_take;
  assign bus.redirect_pc = eret_take ? epc : VEC_ADDR;
  assign bus.status_o    = status_w;
  assign bus.cause_o     = cause_w;
  assign bus.epc_o       = epc;

endmodule
